reservation_station: RTL
========================

Name: reservation_station

Overview:
- Arithmetic reservation station of the out-of-order core, directly downstream of the dispatcher.
- Accepts one arithmetic op per cycle with operands as values or ROB tags, and snoops the ALU and LSB CDBs to resolve tags.
- Issues at most one operand-complete op per cycle to the ALU.
- Reports full back to the dispatcher.
- Flushes all entries on ROB misprediction clear.

Parameters:
- RS_SIZE, 16, number of entries.
- RS_WIDTH, 4, log2(RS_SIZE); entry index width.
- ROB_WIDTH, 4, ROB tag width. Tag 0 is never allocated by the ROB; q==0 means operand ready.
- OP_WIDTH, 6, internal opcode width.
- ADDR_WIDTH, 32, pc width.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- clear_rob_in  in  1  misprediction flush from ROB.
- rdy_dispatch_in  in  1  dispatcher presents an op this cycle.
- pc_dispatch_in  in  ADDR_WIDTH  instruction pc.
- opcode_dispatch_in  in  OP_WIDTH  opcode.
- qj_dispatch_in, qk_dispatch_in  in  ROB_WIDTH each  producer tags; 0 = value valid.
- vj_dispatch_in, vk_dispatch_in  in  32 each  operand values.
- A_dispatch_in  in  32  immediate.
- rob_id_dispatch_in  in  ROB_WIDTH+1  destination ROB id; carried unmodified.
- rs_full_out  out  1  no free entry; combinational from registered valid bits.
- cdb_alu_valid_in  in  1  ALU CDB broadcast valid.
- cdb_alu_rob_in  in  ROB_WIDTH  ALU CDB tag.
- cdb_alu_val_in  in  32  ALU CDB value.
- cdb_lsb_valid_in  in  1  LSB CDB broadcast valid.
- cdb_lsb_rob_in  in  ROB_WIDTH  LSB CDB tag.
- cdb_lsb_val_in  in  32  LSB CDB value.
- rdy_alu_out  out  1  registered; ALU op valid this cycle.
- pc_alu_out  out  ADDR_WIDTH  registered.
- opcode_alu_out  out  OP_WIDTH  registered.
- vj_alu_out, vk_alu_out, A_alu_out  out  32 each  registered.
- rob_id_alu_out  out  ROB_WIDTH+1  registered.

Behaviour:
- Reset (async, rst_in high):
  - All entry valid bits cleared.
  - rdy_alu_out=0; all ALU data outputs=0.
  - rs_full_out=0.
  - Reset mid-operation discards every entry and any pending issue.
- rdy_in low: no allocation, no issue, no CDB capture; entries hold; rdy_alu_out driven 0 next edge.
- Entry fields: valid, pc, opcode, qj, qk, vj, vk, A, rob_id.
- Allocation:
  - On an edge with rdy_dispatch_in=1 and a free entry, write the lowest-index invalid entry and set valid.
  - rdy_dispatch_in while rs_full_out=1 is a protocol violation: ignored, no state change.
- Dispatch-cycle bypass:
  - If incoming qj (qk) is nonzero and equals a valid CDB tag in the same cycle, store q=0 and v=CDB value.
  - ALU CDB has priority if both CDB tags match.
- CDB snoop: every edge, each valid entry with qj!=0 matching a valid CDB tag gets qj<=0, vj<=value; same for qk, independently for both buses.
- Select: entry is ready when valid && qj==0 && qk==0 in the registered state. The lowest-index ready entry is selected.
- Issue:
  - On the edge, copy the selected entry's fields to the ALU outputs, set rdy_alu_out=1 and clear that entry's valid bit.
  - If no entry is ready, rdy_alu_out<=0 and data outputs hold.
  - rdy_alu_out is a one-cycle pulse per issued op.
- Latency:
  - Op dispatched with both operands ready at edge E0 issues at E1 at the earliest; rdy_alu_out is high in the cycle after E1.
  - An entry woken by CDB at edge E issues at E+1 at the earliest.
  - Allocation, snoop and issue may all occur on the same edge and affect different entries.
  - A just-allocated entry is never issued on its allocation edge.
- Full:
  - rs_full_out = all RS_SIZE entries valid (registered state).
  - An issue on the same edge frees the slot for the following cycle only.
- Flush:
  - clear_rob_in=1 at an edge invalidates all entries and sets rdy_alu_out<=0.
  - Flush overrides allocation and issue on that edge.

Test Plan:
- Reset mid-operation: fill 3 entries, assert rst_in between edges -> rdy_alu_out=0 immediately; rs_full_out=0; no issue afterward.
- Ready op: dispatch opcode=ADD, qj=qk=0, vj=5, vk=7, rob_id=3 at E0 -> rdy_alu_out=1 in cycle after E1 with vj_alu_out=5, vk_alu_out=7, rob_id_alu_out=3; pulse lasts exactly one cycle.
- CDB wakeup: dispatch qj=2, vk=1. ALU CDB broadcasts tag 2, val 0x10 at E3 -> issue at E4 with vj_alu_out=0x10, vk_alu_out=1. A broadcast of tag 5 causes no issue.
- Same-cycle bypass and priority: dispatch qj=4 while ALU CDB tag 4=0xAA and LSB CDB tag 4=0xBB -> entry issues next edge with vj=0xAA.
- Full: dispatch 16 dependent ops (qj=6) -> rs_full_out=1 after the 16th edge. A 17th dispatch is ignored. CDB tag 6 wakes all; entries 0..15 issue in index order on 16 consecutive edges, and rs_full_out drops after the first issue.
- Flush: 4 waiting entries, clear_rob_in=1 together with rdy_dispatch_in -> all invalid, rdy_alu_out=0 next cycle, the concurrent dispatch is dropped, and later CDB tags issue nothing.

Source files
------------

// File: rtl/reservation_station.sv
// Arithmetic reservation station: buffers dispatched ops until both operands are
// resolved (directly or via ALU/LSB CDB snoop), then issues the lowest ready entry to the ALU.
module reservation_station #(
    parameter int unsigned RS_SIZE    = 16,
    parameter int unsigned RS_WIDTH   = 4,
    parameter int unsigned ROB_WIDTH  = 4,
    parameter int unsigned OP_WIDTH   = 6,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_rob_in,
    input  logic                  rdy_dispatch_in,
    input  logic [ADDR_WIDTH-1:0] pc_dispatch_in,
    input  logic [OP_WIDTH-1:0]   opcode_dispatch_in,
    input  logic [ROB_WIDTH-1:0]  qj_dispatch_in,
    input  logic [ROB_WIDTH-1:0]  qk_dispatch_in,
    input  logic [31:0]           vj_dispatch_in,
    input  logic [31:0]           vk_dispatch_in,
    input  logic [31:0]           A_dispatch_in,
    input  logic [ROB_WIDTH:0]    rob_id_dispatch_in,
    output logic                  rs_full_out,
    input  logic                  cdb_alu_valid_in,
    input  logic [ROB_WIDTH-1:0]  cdb_alu_rob_in,
    input  logic [31:0]           cdb_alu_val_in,
    input  logic                  cdb_lsb_valid_in,
    input  logic [ROB_WIDTH-1:0]  cdb_lsb_rob_in,
    input  logic [31:0]           cdb_lsb_val_in,
    output logic                  rdy_alu_out,
    output logic [ADDR_WIDTH-1:0] pc_alu_out,
    output logic [OP_WIDTH-1:0]   opcode_alu_out,
    output logic [31:0]           vj_alu_out,
    output logic [31:0]           vk_alu_out,
    output logic [31:0]           A_alu_out,
    output logic [ROB_WIDTH:0]    rob_id_alu_out
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [OP_WIDTH-1:0]   opcode;
        logic [ROB_WIDTH-1:0]  qj;
        logic [ROB_WIDTH-1:0]  qk;
        logic [31:0]           vj;
        logic [31:0]           vk;
        logic [31:0]           a;
        logic [ROB_WIDTH:0]    rob_id;
    } entry_t;

    entry_t              entries [RS_SIZE];
    logic [RS_SIZE-1:0]  valid;
    logic [RS_WIDTH-1:0] free_idx;
    logic [RS_WIDTH-1:0] sel_idx;
    logic                free_found;
    logic                sel_found;
    entry_t              alloc_entry;

    assign rs_full_out = &valid;

    // Lowest free slot for allocation and lowest operand-complete slot for issue.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = RS_WIDTH'(i);
            end else if (entries[i].qj == '0 && entries[i].qk == '0) begin
                sel_found = 1'b1;
                sel_idx   = RS_WIDTH'(i);
            end
        end
    end

    // Incoming op with same-cycle CDB bypass; ALU bus wins when both tags match.
    always_comb begin
        alloc_entry.pc     = pc_dispatch_in;
        alloc_entry.opcode = opcode_dispatch_in;
        alloc_entry.qj     = qj_dispatch_in;
        alloc_entry.qk     = qk_dispatch_in;
        alloc_entry.vj     = vj_dispatch_in;
        alloc_entry.vk     = vk_dispatch_in;
        alloc_entry.a      = A_dispatch_in;
        alloc_entry.rob_id = rob_id_dispatch_in;
        if (qj_dispatch_in != '0) begin
            if (cdb_alu_valid_in && cdb_alu_rob_in == qj_dispatch_in) begin
                alloc_entry.qj = '0;
                alloc_entry.vj = cdb_alu_val_in;
            end else if (cdb_lsb_valid_in && cdb_lsb_rob_in == qj_dispatch_in) begin
                alloc_entry.qj = '0;
                alloc_entry.vj = cdb_lsb_val_in;
            end
        end
        if (qk_dispatch_in != '0) begin
            if (cdb_alu_valid_in && cdb_alu_rob_in == qk_dispatch_in) begin
                alloc_entry.qk = '0;
                alloc_entry.vk = cdb_alu_val_in;
            end else if (cdb_lsb_valid_in && cdb_lsb_rob_in == qk_dispatch_in) begin
                alloc_entry.qk = '0;
                alloc_entry.vk = cdb_lsb_val_in;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid          <= '0;
            rdy_alu_out    <= 1'b0;
            pc_alu_out     <= '0;
            opcode_alu_out <= '0;
            vj_alu_out     <= '0;
            vk_alu_out     <= '0;
            A_alu_out      <= '0;
            rob_id_alu_out <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entries[i] <= '0;
            end
        end else if (!rdy_in) begin
            rdy_alu_out <= 1'b0;
        end else if (clear_rob_in) begin
            valid       <= '0;
            rdy_alu_out <= 1'b0;
        end else begin
            // Snoop both CDBs into waiting entries.
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (valid[i]) begin
                    if (entries[i].qj != '0) begin
                        if (cdb_alu_valid_in && cdb_alu_rob_in == entries[i].qj) begin
                            entries[i].qj <= '0;
                            entries[i].vj <= cdb_alu_val_in;
                        end else if (cdb_lsb_valid_in && cdb_lsb_rob_in == entries[i].qj) begin
                            entries[i].qj <= '0;
                            entries[i].vj <= cdb_lsb_val_in;
                        end
                    end
                    if (entries[i].qk != '0) begin
                        if (cdb_alu_valid_in && cdb_alu_rob_in == entries[i].qk) begin
                            entries[i].qk <= '0;
                            entries[i].vk <= cdb_alu_val_in;
                        end else if (cdb_lsb_valid_in && cdb_lsb_rob_in == entries[i].qk) begin
                            entries[i].qk <= '0;
                            entries[i].vk <= cdb_lsb_val_in;
                        end
                    end
                end
            end

            rdy_alu_out <= sel_found;
            if (sel_found) begin
                pc_alu_out       <= entries[sel_idx].pc;
                opcode_alu_out   <= entries[sel_idx].opcode;
                vj_alu_out       <= entries[sel_idx].vj;
                vk_alu_out       <= entries[sel_idx].vk;
                A_alu_out        <= entries[sel_idx].a;
                rob_id_alu_out   <= entries[sel_idx].rob_id;
                valid[sel_idx]   <= 1'b0;
            end

            // Free slot is never the issuing slot, so both can happen on one edge.
            if (rdy_dispatch_in && free_found) begin
                entries[free_idx] <= alloc_entry;
                valid[free_idx]   <= 1'b1;
            end
        end
    end

endmodule
